// File: rtl/and16_arb_pkg.sv
// rtl/and16_arb_pkg.sv - shared width constant and FSM state encoding for the AND16 arbiter
package and16_arb_pkg;

  localparam int AND16_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/and16_arbiter_if.sv
// rtl/and16_arbiter_if.sv - two-requester handshake bus between requesters and the AND16 arbiter
interface and16_arbiter_if
  import and16_arb_pkg::*;
#(
  parameter int WIDTH = AND16_DEFAULT_WIDTH
) ();

  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             ack0;
  logic             ack1;
  logic [WIDTH-1:0] out;
  logic             busy;

  // requester side
  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  ack0, ack1, out, busy
  );

  // arbiter side
  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output ack0, ack1, out, busy
  );

endinterface

// File: rtl/and16.sv
// rtl/and16.sv - combinational bitwise AND datapath shared by both requesters
module and16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a & b;

endmodule

// File: rtl/and16_arbiter.sv
// rtl/and16_arbiter.sv - two-requester arbiter around one AND16 datapath; AND16_ARB_RR_EN enables round-robin
module and16_arbiter
  import and16_arb_pkg::*;
#(
  parameter int WIDTH = AND16_DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  and16_arbiter_if.slave bus
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] and_y;
  logic [WIDTH-1:0] out_q;
  logic             grant;
  logic             grant_nxt;
  logic             any_req;
  logic             capture_en;
  logic             load_en;
  logic             done0;
  logic             done1;
  logic             ack0_q;
  logic             ack1_q;

  assign any_req = bus.req0 | bus.req1;

  and16 #(.WIDTH(WIDTH)) u_and16 (
    .a (opa),
    .b (opb),
    .y (and_y)
  );

`ifdef AND16_ARB_RR_EN
  logic last_grant;

  // last-grant pointer: moves to the served requester when its operation completes
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (state == DONE) begin
      last_grant <= grant;
    end
  end

  // round-robin pick: on a tie favour the requester not served last
  always_comb begin
    grant_nxt = 1'b0;
    if (bus.req0 && bus.req1) begin
      grant_nxt = ~last_grant;
    end else begin
      grant_nxt = ~bus.req0;
    end
  end
`else
  // fixed-priority pick: requester 0 wins every tie
  always_comb begin
    grant_nxt = ~bus.req0;
  end
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state: one step per clock once a request is taken
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = any_req ? EXEC : IDLE;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // per-state control strobes
  always_comb begin
    capture_en = (state == IDLE) && any_req;
    load_en    = (state == EXEC);
    done0      = (state == DONE) && !grant;
    done1      = (state == DONE) && grant;
  end

  // operand capture at grant, result load in EXEC, registered ack pulse out of DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      opa    <= '0;
      opb    <= '0;
      grant  <= 1'b0;
      out_q  <= '0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
    end else begin
      if (capture_en) begin
        opa   <= grant_nxt ? bus.a1 : bus.a0;
        opb   <= grant_nxt ? bus.b1 : bus.b0;
        grant <= grant_nxt;
      end
      if (load_en) begin
        out_q <= and_y;
      end
      ack0_q <= done0;
      ack1_q <= done1;
    end
  end

  assign bus.ack0 = ack0_q;
  assign bus.ack1 = ack1_q;
  assign bus.out  = out_q;
  assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_and16_arbiter.sv
// tb/tb_and16_arbiter.sv - directed self-checking bench for and16_arbiter
module tb_and16_arbiter;
  import and16_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  and16_arbiter_if #(.WIDTH(16)) bus ();

  and16_arbiter #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        sel;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic sel, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_out, input string tag);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    if (!sel) begin
      bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1;
    end else begin
      bus.a1 = a; bus.b1 = b; bus.req1 = 1'b1;
    end
    while (!seen && n < 10) begin
      tick();
      n++;
      if (bus.ack0 || bus.ack1) seen = 1;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    chk({tag, " latency"}, n, 3);
    chk({tag, " own ack"}, sel ? bus.ack1 : bus.ack0, 1);
    chk({tag, " other ack"}, sel ? bus.ack0 : bus.ack1, 0);
    chk({tag, " out"}, bus.out, exp_out);
    chk({tag, " busy at ack"}, bus.busy, 0);
  endtask

  initial begin
    int          order[$];
    int          ack_cyc[$];
    int          n;
    int          stray;
    logic [15:0] exp_hold0;
    logic [15:0] prev_out;

    vecs[0] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 16'hAAAA, 16'hFFFF, 16'hAAAA};
    vecs[2] = '{1'b0, 16'h1234, 16'h0FF0, 16'h0230};
    vecs[3] = '{1'b1, 16'hF00F, 16'hFFFF, 16'hF00F};

    // reset with a request pending: reset wins
    reset = 1'b1;
    bus.req0 = 1'b1; bus.a0 = 16'hFFFF; bus.b0 = 16'hFFFF;
    bus.req1 = 1'b0; bus.a1 = 16'h0000; bus.b1 = 16'h0000;
    tick();
    tick();
    chk("reset busy", bus.busy, 0);
    chk("reset out", bus.out, 16'h0000);
    chk("reset ack0", bus.ack0, 0);
    chk("reset ack1", bus.ack1, 0);
    bus.req0 = 1'b0;
    reset = 1'b0;
    tick();

    // single-requester table
    for (int i = 0; i < 4; i++) begin
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp_out, $sformatf("vec%0d", i));
    end

    // simultaneous requests, each dropped on its ack
    bus.a0 = 16'hCCCC; bus.b0 = 16'hAAAA;
    bus.a1 = 16'hF0F0; bus.b1 = 16'h0FF0;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    n = 0;
    order.delete();
    while (order.size() < 2 && n < 20) begin
      tick();
      n++;
      chk("pair ack exclusive", bus.ack0 & bus.ack1, 0);
      if (bus.ack0) begin
        order.push_back(0);
        chk("pair out0", bus.out, 16'h8888);
        bus.req0 = 1'b0;
      end
      if (bus.ack1) begin
        order.push_back(1);
        chk("pair out1", bus.out, 16'h00F0);
        bus.req1 = 1'b0;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    chk("pair ack count", order.size(), 2);
    if (order.size() == 2) begin
      chk("pair first", order[0], 0);
      chk("pair second", order[1], 1);
    end
    tick();

    // both held for four operations
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    n = 0;
    order.delete();
    ack_cyc.delete();
    while (order.size() < 4 && n < 30) begin
      tick();
      n++;
      chk("hold ack exclusive", bus.ack0 & bus.ack1, 0);
      if (bus.ack0) begin order.push_back(0); ack_cyc.push_back(n); end
      if (bus.ack1) begin order.push_back(1); ack_cyc.push_back(n); end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    chk("hold ack count", order.size(), 4);
    if (order.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
`ifdef AND16_ARB_RR_EN
        chk($sformatf("hold order%0d", i), order[i], i % 2);
`else
        chk($sformatf("hold order%0d", i), order[i], 0);
`endif
      end
      chk("hold first latency", ack_cyc[0], 3);
      for (int i = 1; i < 4; i++) begin
        chk($sformatf("hold spacing%0d", i), ack_cyc[i] - ack_cyc[i-1], 3);
      end
    end
    for (int i = 0; i < 6; i++) tick();

`ifdef AND16_ARB_RR_EN
    exp_hold0 = 16'h00F0;
`else
    exp_hold0 = 16'h8888;
`endif
    chk("out held after hold", bus.out, exp_hold0);

    // operands change and request drops after grant
    bus.a0 = 16'hFFFF; bus.b0 = 16'hFFFF; bus.req0 = 1'b1;
    tick();
    chk("late busy exec", bus.busy, 1);
    bus.a0 = 16'h0000; bus.req0 = 1'b0;
    prev_out = exp_hold0;
    chk("late out held in exec", bus.out, prev_out);
    tick();
    chk("late ack0 not early", bus.ack0, 0);
    tick();
    chk("late ack0", bus.ack0, 1);
    chk("late out", bus.out, 16'hFFFF);
    tick();
    chk("late ack0 one cycle", bus.ack0, 0);

    // reset in the EXEC cycle abandons the operation
    bus.a1 = 16'h5555; bus.b1 = 16'h5555; bus.req1 = 1'b1;
    tick();
    chk("abort busy exec", bus.busy, 1);
    reset = 1'b1; bus.req1 = 1'b0;
    tick();
    chk("abort out", bus.out, 16'h0000);
    chk("abort busy", bus.busy, 0);
    chk("abort ack0", bus.ack0, 0);
    chk("abort ack1", bus.ack1, 0);
    reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.ack0 || bus.ack1 || bus.busy) stray++;
    end
    chk("abort no stray ack", stray, 0);

    // recovery after reset
    run_op(1'b0, 16'h0F0F, 16'h00FF, 16'h000F, "recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
